tribus_arbiter: RTL

- Round-robin arbiter and sequencer for a shared tri-state bus built from tribuf cells.
- Each requester drives the bus through its own tribuf; this block produces the one-hot enable set (GNT) wired to the tribuf E pins.
- Guarantees at most one driver at any time, inserts one break-before-make turnaround cycle between owners, and bounds ownership time when others are waiting.

---
 rtl/tribus_arbiter_pkg.sv | 11 +
 rtl/tribus_arbiter_rr_pick.sv | 29 ++
 rtl/tribus_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/tribus_arbiter_pkg.sv
`timescale 1ns/10ps
// Shared FSM state encoding for the tri-state bus arbiter.
package tribus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } state_t;

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
`timescale 1ns/10ps
// Circular first-set-bit finder: first REQ bit at or after PTR, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  REQ,
    input  logic [IW-1:0] PTR,
    output logic          VALID,
    output logic [IW-1:0] IDX
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Rotate requests so PTR lands on bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {REQ, REQ} >> PTR;
        rot   = dbl[N-1:0];
        VALID = |rot;
        IDX   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                IDX = IW'((int'(PTR) + k) % N);
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
`timescale 1ns/10ps
// Round-robin owner sequencer for a tribuf-driven shared bus.
// Produces one-hot (or zero) enables with a one-cycle gap between owners
// and a bounded hold time when other requesters are waiting.
module tribus_arbiter
    import tribus_arbiter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned MAXHOLD = 8,
    localparam int unsigned IW     = $clog2(N)
) (
    input  logic          CK,
    input  logic          R,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  GNT,
    output logic [IW-1:0] OWNER,
    output logic          BUSY
);

    localparam int unsigned CW = $clog2(MAXHOLD + 1);

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] owner_n;
    logic          busy_n;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          others_req;

    rr_pick #(.N(N)) u_pick (
        .REQ   (REQ),
        .PTR   (ptr),
        .VALID (pick_valid),
        .IDX   (pick_idx)
    );

    // State and output registers; reset clears enables immediately.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            GNT   <= '0;
            OWNER <= '0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            GNT   <= gnt_n;
            OWNER <= owner_n;
            BUSY  <= busy_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        gnt_n      = GNT;
        owner_n    = OWNER;
        busy_n     = BUSY;
        // While granted, GNT is onehot(OWNER), so it doubles as the owner mask.
        owner_req  = |(REQ & GNT);
        others_req = |(REQ & ~GNT);

        case (state)
            IDLE, TURN: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    gnt_n   = N'(1) << pick_idx;
                    owner_n = pick_idx;
                    busy_n  = 1'b1;
                    cnt_n   = CW'(1);
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req || (cnt == CW'(MAXHOLD) && others_req)) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = (OWNER == IW'(N - 1)) ? '0 : OWNER + IW'(1);
                end else if (cnt != CW'(MAXHOLD)) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
